// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state encoding, song word layout and field helpers
// for note_sequencer and its song ROM.
package note_seq_pkg;

    localparam int WORD_W    = 10;
    localparam int PITCH_W   = 6;
    localparam int LEN_W     = 3;
    localparam int PITCH_LSB = 0;
    localparam int LEN_LSB   = 6;
    localparam int END_BIT   = 9;

    localparam logic [PITCH_W-1:0] PITCH_REST = '0;
    localparam logic [LEN_W-1:0]   LEN_NONE   = '0;

    typedef logic [WORD_W-1:0] song_word_t;

    // A lone end marker; used as the default (empty) song image.
    localparam song_word_t END_WORD = song_word_t'(1 << END_BIT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        DONE
    } seq_state_t;

    function automatic logic [PITCH_W-1:0] word_pitch(input song_word_t w);
        return w[PITCH_LSB +: PITCH_W];
    endfunction

    function automatic logic [LEN_W-1:0] word_length(input song_word_t w);
        return w[LEN_LSB +: LEN_W];
    endfunction

    function automatic logic word_is_end(input song_word_t w);
        return w[END_BIT];
    endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: ROM_DEPTH x WORD_W song table with a one-cycle registered read.
// The table is baked in from SONG_IMAGE; word i sits at bits [i*WORD_W +: WORD_W].
module song_rom
    import note_seq_pkg::*;
#(
    parameter int ROM_DEPTH = 64,
    parameter int ADDR_W    = 6,
    parameter logic [ROM_DEPTH*WORD_W-1:0] SONG_IMAGE = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output song_word_t        data
);

    song_word_t table_words [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_word
        assign table_words[i] = SONG_IMAGE[i*WORD_W +: WORD_W];
    end

    always_ff @(posedge clk) begin
        data <= table_words[addr];
    end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks a song ROM one note per playNext pulse and presents pitch/length.
// Build option: define NOTE_SEQ_LOOP_EN to restart the song from address 0 instead of stopping.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int ROM_DEPTH = 64,
    parameter int ADDR_W    = 6,
    parameter logic [ROM_DEPTH*WORD_W-1:0] SONG_IMAGE =
        {{((ROM_DEPTH-1)*WORD_W){1'b0}}, END_WORD}
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               run,
    input  logic               playNext,
    output logic [PITCH_W-1:0] pitch,
    output logic [LEN_W-1:0]   length,
    output logic               note_valid,
    output logic [ADDR_W-1:0]  song_addr,
    output logic               song_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

    seq_state_t state;
    seq_state_t state_next;
    song_word_t rom_data;
    logic       at_last;
    logic       song_end;
    logic       advance;
    logic       restart;

    song_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .ADDR_W    (ADDR_W),
        .SONG_IMAGE(SONG_IMAGE)
    ) rom (
        .clk (CLOCK_50),
        .addr(song_addr),
        .data(rom_data)
    );

    // Running off the last address counts as an end marker, so the address never wraps mid-song.
    assign at_last  = (song_addr == LAST_ADDR);
    assign song_end = run && (((state == LOAD) && word_is_end(rom_data)) ||
                              ((state == PLAY) && playNext && at_last));
    assign advance  = run && (state == PLAY) && playNext && !at_last;

`ifdef NOTE_SEQ_LOOP_EN
    // An end marker at address 0 still stops, otherwise an empty song would pulse forever.
    assign restart = song_end && (song_addr != '0);
`else
    assign restart = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!run) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = FETCH;
                FETCH:   state_next = LOAD;
                LOAD: begin
                    if (song_end) begin
                        state_next = restart ? FETCH : DONE;
                    end else begin
                        state_next = PLAY;
                    end
                end
                PLAY: begin
                    if (song_end) begin
                        state_next = restart ? FETCH : DONE;
                    end else if (playNext) begin
                        state_next = FETCH;
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        note_valid = 1'b0;
        song_done  = 1'b0;
        if (state == PLAY) begin
            note_valid = !playNext;
        end
        song_done = song_end;
    end

    // Pitch/length only change on a real note load, so the timer's length input never glitches.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn || !run) begin
            song_addr <= '0;
            pitch     <= PITCH_REST;
            length    <= LEN_NONE;
        end else begin
            if ((state == LOAD) && !word_is_end(rom_data)) begin
                pitch  <= word_pitch(rom_data);
                length <= word_length(rom_data);
            end
            if (restart) begin
                song_addr <= '0;
            end else if (advance) begin
                song_addr <= song_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: three note_sequencer instances with different songs, checked every
// cycle against a note-countdown model plus hand-computed expectations.
module tb_note_sequencer;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int NDUT  = 3;

`ifdef NOTE_SEQ_LOOP_EN
    localparam bit LOOP_BUILD = 1'b1;
`else
    localparam bit LOOP_BUILD = 1'b0;
`endif

    // Song 0: {len2/p12, len4/rest, END}; song 1: 64 notes, no marker; song 2: END at address 0.
    function automatic logic [9:0] song_word(input int k, input int i);
        logic [9:0] w;
        w = '0;
        if (k == 0) begin
            if (i == 0)      w = {1'b0, 3'd2, 6'd12};
            else if (i == 1) w = {1'b0, 3'd4, 6'd0};
            else if (i == 2) w = 10'h200;
        end else if (k == 1) begin
            w = {1'b0, 3'(i % 8), 6'(i)};
        end else begin
            w = (i == 0) ? 10'h200 : {1'b0, 3'd1, 6'd5};
        end
        return w;
    endfunction

    function automatic logic [DEPTH*10-1:0] song_image(input int k);
        logic [DEPTH*10-1:0] img;
        img = '0;
        for (int i = 0; i < DEPTH; i++) img[i*10 +: 10] = song_word(k, i);
        return img;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      resetn = 1'b0;
    logic [NDUT-1:0]           run_v  = '0;
    logic [NDUT-1:0]           play_v = '0;
    logic [NDUT-1:0][5:0]      pitch_v;
    logic [NDUT-1:0][2:0]      len_v;
    logic [NDUT-1:0]           valid_v;
    logic [NDUT-1:0][AW-1:0]   addr_v;
    logic [NDUT-1:0]           done_v;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        note_sequencer #(
            .ROM_DEPTH (DEPTH),
            .ADDR_W    (AW),
            .SONG_IMAGE(song_image(k))
        ) dut (
            .CLOCK_50  (clk),
            .resetn    (resetn),
            .run       (run_v[k]),
            .playNext  (play_v[k]),
            .pitch     (pitch_v[k]),
            .length    (len_v[k]),
            .note_valid(valid_v[k]),
            .song_addr (addr_v[k]),
            .song_done (done_v[k])
        );
    end

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model: m_cnt counts cycles until the fetched note sounds (2 = fetching, 1 = loading, 0 = playing).
    logic [9:0] songs [NDUT][DEPTH];
    int         m_addr     [NDUT];
    int         m_cnt      [NDUT];
    bit         m_active   [NDUT];
    bit         m_finished [NDUT];
    logic [5:0] m_pitch    [NDUT];
    logic [2:0] m_len      [NDUT];
    bit         model_ready = 1'b0;

    initial begin
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < DEPTH; i++) songs[k][i] = song_word(k, i);
    end

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!resetn || !run_v[k]) begin
                m_active[k]   <= 1'b0;
                m_finished[k] <= 1'b0;
                m_addr[k]     <= 0;
                m_cnt[k]      <= 0;
                m_pitch[k]    <= '0;
                m_len[k]      <= '0;
            end else if (!m_active[k]) begin
                m_active[k] <= 1'b1;
                m_cnt[k]    <= 2;
            end else if (!m_finished[k]) begin
                if (m_cnt[k] == 2) begin
                    m_cnt[k] <= 1;
                end else if (m_cnt[k] == 1) begin
                    m_cnt[k] <= 0;
                    if (songs[k][m_addr[k]][9]) begin
                        if (LOOP_BUILD && m_addr[k] != 0) begin
                            m_addr[k] <= 0;
                            m_cnt[k]  <= 2;
                        end else begin
                            m_finished[k] <= 1'b1;
                        end
                    end else begin
                        m_pitch[k] <= songs[k][m_addr[k]][5:0];
                        m_len[k]   <= songs[k][m_addr[k]][8:6];
                    end
                end else if (play_v[k]) begin
                    if (m_addr[k] == DEPTH - 1) begin
                        if (LOOP_BUILD) begin
                            m_addr[k] <= 0;
                            m_cnt[k]  <= 2;
                        end else begin
                            m_finished[k] <= 1'b1;
                        end
                    end else begin
                        m_addr[k] <= m_addr[k] + 1;
                        m_cnt[k]  <= 2;
                    end
                end
            end
        end
        if (!resetn) model_ready <= 1'b1;
    end

    initial begin : compare
        bit   playing;
        logic exp_valid;
        logic exp_done;
        forever begin
            @(negedge clk);
            #2;
            if (model_ready) begin
                for (int k = 0; k < NDUT; k++) begin
                    playing   = m_active[k] && !m_finished[k] && (m_cnt[k] == 0);
                    exp_valid = playing && !play_v[k];
                    exp_done  = run_v[k] && m_active[k] && !m_finished[k] &&
                                (((m_cnt[k] == 1) && songs[k][m_addr[k]][9]) ||
                                 (playing && play_v[k] && (m_addr[k] == DEPTH - 1)));
                    checkOutput($sformatf("dut%0d note_valid", k), valid_v[k], exp_valid);
                    checkOutput($sformatf("dut%0d song_done", k), done_v[k], exp_done);
                    checkOutput($sformatf("dut%0d song_addr", k), addr_v[k], m_addr[k]);
                    checkOutput($sformatf("dut%0d pitch", k), pitch_v[k], m_pitch[k]);
                    checkOutput($sformatf("dut%0d length", k), len_v[k], m_len[k]);
                end
            end
        end
    end

    // One cycle per call: inputs change at the falling edge, caller may check 3 ns later.
    task automatic applyStimulus(input int k, input logic r, input logic p);
        @(negedge clk);
        run_v[k]  = r;
        play_v[k] = p;
        #3;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #3;
        checkOutput("reset song_addr", addr_v[0], 0);
        checkOutput("reset note_valid", valid_v[0], 0);
        checkOutput("reset pitch", pitch_v[0], 0);
        checkOutput("reset length", len_v[0], 0);
        checkOutput("reset song_done", done_v[0], 0);
        resetn = 1'b1;

        // Song 0: first note three cycles after run, then rest note, then end marker.
        repeat (4) applyStimulus(0, 1'b1, 1'b0);
        checkOutput("A first note valid", valid_v[0], 1);
        checkOutput("A first note pitch", pitch_v[0], 12);
        checkOutput("A first note length", len_v[0], 2);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("A valid drops on pulse", valid_v[0], 0);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("A pitch held in fetch", pitch_v[0], 12);
        checkOutput("A addr after pulse", addr_v[0], 1);
        repeat (2) applyStimulus(0, 1'b1, 1'b0);
        checkOutput("A rest note valid", valid_v[0], 1);
        checkOutput("A rest note pitch", pitch_v[0], 0);
        checkOutput("A rest note length", len_v[0], 4);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("A done before marker", done_v[0], 0);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("A done on marker", done_v[0], 1);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("A done one cycle only", done_v[0], 0);
        repeat (2) applyStimulus(0, 1'b1, 1'b0);
`ifdef NOTE_SEQ_LOOP_EN
        checkOutput("A loop replays pitch", pitch_v[0], 12);
        checkOutput("A loop valid", valid_v[0], 1);
        checkOutput("A loop addr", addr_v[0], 0);
`else
        checkOutput("A idle in done", valid_v[0], 0);
        checkOutput("A done keeps addr", addr_v[0], 2);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("A pulse ignored in done", addr_v[0], 2);
`endif
        repeat (2) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("A stop addr", addr_v[0], 0);
        checkOutput("A stop pitch", pitch_v[0], 0);

        // run drop coinciding with playNext wins; pulses outside PLAY are ignored.
        applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b1);
        repeat (2) applyStimulus(0, 1'b1, 1'b0);
        checkOutput("B addr after fetch pulse", addr_v[0], 0);
        applyStimulus(0, 1'b1, 1'b1);
        repeat (3) applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("B no valid on stop", valid_v[0], 0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("B stop addr no advance", addr_v[0], 0);
        checkOutput("B stop length", len_v[0], 0);

        // Reset mid-song, then restart from address 0.
        repeat (4) applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b1);
        repeat (3) applyStimulus(0, 1'b1, 1'b0);
        resetn = 1'b0;
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("R addr after reset", addr_v[0], 0);
        checkOutput("R valid after reset", valid_v[0], 0);
        resetn = 1'b1;
        repeat (3) applyStimulus(0, 1'b1, 1'b0);
        checkOutput("R restart pitch", pitch_v[0], 12);
        checkOutput("R restart valid", valid_v[0], 1);
        repeat (2) applyStimulus(0, 1'b0, 1'b0);

        // Song 1: 64 markerless notes end on the 64th pulse.
        repeat (4) applyStimulus(1, 1'b1, 1'b0);
        for (int n = 1; n <= DEPTH; n++) begin
            applyStimulus(1, 1'b1, 1'b1);
            if (n == DEPTH) begin
                checkOutput("C done on last pulse", done_v[1], 1);
            end else begin
                repeat (3) applyStimulus(1, 1'b1, 1'b0);
                if (n == DEPTH - 1) begin
                    checkOutput("C last addr", addr_v[1], 63);
                    checkOutput("C last pitch", pitch_v[1], 63);
                    checkOutput("C last length", len_v[1], 7);
                end
            end
        end
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("C done single", done_v[1], 0);
`ifdef NOTE_SEQ_LOOP_EN
        checkOutput("C loop addr", addr_v[1], 0);
`else
        checkOutput("C addr no wrap", addr_v[1], 63);
`endif
        repeat (2) applyStimulus(1, 1'b0, 1'b0);

        // Song 2: empty song gives one pulse then parks in DONE.
        repeat (3) applyStimulus(2, 1'b1, 1'b0);
        checkOutput("D done on empty song", done_v[2], 1);
        applyStimulus(2, 1'b1, 1'b0);
        checkOutput("D done single", done_v[2], 0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(2, 1'b1, 1'b1);
            applyStimulus(2, 1'b1, 1'b0);
        end
        checkOutput("D stays silent", done_v[2], 0);
        checkOutput("D addr stays", addr_v[2], 0);
        repeat (2) applyStimulus(2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
